// File: rtl/mod_type_detector.sv
// mod_type_detector: classifies the ADC stream per measurement window as AM,
// ASK or unmodulated carrier (CW), filters the decision with hysteresis and
// computes the AM modulation depth in percent with a restoring divider.
// A window is SUBWIN*NSUB accepted samples; statistics run one accepted
// sample behind the input because they use the registered rectifier output.
module mod_type_detector #(
    parameter int ADC_W  = 10,
    parameter int SUBWIN = 64,
    parameter int NSUB   = 156,
    parameter int LOW_TH = 10,
    parameter int ASK_TH = 2000,
    parameter int CW_TH  = 8,
    parameter int HYST   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [ADC_W-1:0] ad_data,
    output logic [1:0]       type_out,
    output logic             type_valid,
    output logic             type_changed,
    output logic             win_done,
    output logic [ADC_W-2:0] env_max,
    output logic [ADC_W-2:0] env_min,
    output logic [6:0]       depth_pct,
    output logic             depth_valid
);

    localparam int MW  = ADC_W - 1;                     // magnitude width
    localparam int LCW = $clog2(SUBWIN * NSUB + 1);     // low-sample counter
    localparam int SCW = (SUBWIN > 1) ? $clog2(SUBWIN) : 1;
    localparam int BCW = $clog2(NSUB);
    localparam int NW  = ADC_W + 7;                     // dividend / quotient bits
    localparam int DCW = $clog2(NW + 1);
    localparam int STW = $clog2(HYST + 1);
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};
    localparam logic [ADC_W:0] MID_C  = {2'b01, {(ADC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        T_NONE = 2'b00,
        T_AM   = 2'b01,
        T_ASK  = 2'b10,
        T_CW   = 2'b11
    } mod_type_e;

    // Stage 1 signals
    logic signed [ADC_W:0] centered_s;
    logic [ADC_W:0]        abs_s;
    logic [MW-1:0]         rect_s;
    logic [MW-1:0]         rect_r;
    logic                  s1_vld_r;

    // Window statistics
    logic [MW-1:0]  sub_peak_r, win_max_r, win_min_r;
    logic [LCW-1:0] low_cnt_r, low_fin_r;
    logic [SCW-1:0] sub_cnt_r;
    logic [BCW-1:0] blk_cnt_r;
    logic [MW-1:0]  peak_now_s, wmax_next_s, wmin_next_s;
    logic [LCW-1:0] low_next_s;
    logic           low_hit_s, sub_last_s, win_last_s;

    // Decision and hysteresis
    logic [MW-1:0]  diff_s;
    mod_type_e      cand_s, prev_cand_r;
    logic [1:0]     type_nx_s;
    logic           changed_nx_s;
    logic [STW-1:0] streak_r, streak_nx_s, run_s;

    // Divider
    logic [NW-1:0]    num_s, q_in_s, q_out_s, div_q_r;
    logic [ADC_W-1:0] den_s, den_in_s, rem_in_s, rem_out_s, div_rem_r, div_den_r;
    logic [ADC_W:0]   rem_sh_s;
    logic             q_bit_s, div_busy_r;
    logic [DCW-1:0]   div_cnt_r;
    logic [6:0]       clip_s;

    // Center the offset-binary sample and rectify with saturation
    always_comb begin
        centered_s = $signed({1'b0, ad_data}) - $signed(MID_C);
        if (centered_s[ADC_W]) begin
            abs_s = $unsigned(-centered_s);
        end else begin
            abs_s = $unsigned(centered_s);
        end
        if (abs_s > {2'b00, MAG_MAX}) begin
            rect_s = MAG_MAX;
        end else begin
            rect_s = abs_s[MW-1:0];
        end
    end

    // Stage-1 register: capture rectified magnitude of each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect_r   <= {MW{1'b0}};
            s1_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= sample_en;
            if (sample_en) begin
                rect_r <= rect_s;
            end
        end
    end

    // Per-sample statistic updates including the current stage-1 sample
    always_comb begin
        low_hit_s   = (int'(rect_r) < LOW_TH);
        low_next_s  = low_cnt_r + LCW'(low_hit_s);
        peak_now_s  = (rect_r > sub_peak_r) ? rect_r : sub_peak_r;
        wmax_next_s = (peak_now_s > win_max_r) ? peak_now_s : win_max_r;
        wmin_next_s = (peak_now_s < win_min_r) ? peak_now_s : win_min_r;
        sub_last_s  = (sub_cnt_r == SCW'(SUBWIN - 1));
        win_last_s  = sub_last_s && (blk_cnt_r == BCW'(NSUB - 1));
    end

    // Window accumulators and sub-block / window position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_r  <= {LCW{1'b0}};
            sub_peak_r <= {MW{1'b0}};
            win_max_r  <= {MW{1'b0}};
            win_min_r  <= MAG_MAX;
            sub_cnt_r  <= {SCW{1'b0}};
            blk_cnt_r  <= {BCW{1'b0}};
        end else if (s1_vld_r) begin
            if (win_last_s) begin
                low_cnt_r  <= {LCW{1'b0}};
                sub_peak_r <= {MW{1'b0}};
                win_max_r  <= {MW{1'b0}};
                win_min_r  <= MAG_MAX;
                sub_cnt_r  <= {SCW{1'b0}};
                blk_cnt_r  <= {BCW{1'b0}};
            end else begin
                low_cnt_r <= low_next_s;
                if (sub_last_s) begin
                    sub_peak_r <= {MW{1'b0}};
                    sub_cnt_r  <= {SCW{1'b0}};
                    blk_cnt_r  <= blk_cnt_r + BCW'(1'b1);
                    win_max_r  <= wmax_next_s;
                    win_min_r  <= wmin_next_s;
                end else begin
                    sub_peak_r <= peak_now_s;
                    sub_cnt_r  <= sub_cnt_r + SCW'(1'b1);
                end
            end
        end
    end

    // Window-end snapshot: pulse win_done and publish the finished envelope
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_done  <= 1'b0;
            env_max   <= {MW{1'b0}};
            env_min   <= {MW{1'b0}};
            low_fin_r <= {LCW{1'b0}};
        end else if (s1_vld_r && win_last_s) begin
            win_done  <= 1'b1;
            env_max   <= wmax_next_s;
            env_min   <= wmin_next_s;
            low_fin_r <= low_next_s;
        end else begin
            win_done <= 1'b0;
        end
    end

    // Raw window decision and hysteresis next state
    always_comb begin
        diff_s = env_max - env_min;
        if (int'(low_fin_r) > ASK_TH) begin
            cand_s = T_ASK;
        end else if (int'(diff_s) <= CW_TH) begin
            cand_s = T_CW;
        end else begin
            cand_s = T_AM;
        end
        type_nx_s    = type_out;
        changed_nx_s = 1'b0;
        streak_nx_s  = streak_r;
        run_s        = STW'(1'b1);
        if (!type_valid) begin
            type_nx_s    = cand_s;
            changed_nx_s = 1'b1;
            streak_nx_s  = {STW{1'b0}};
        end else if (cand_s == mod_type_e'(type_out)) begin
            streak_nx_s = {STW{1'b0}};
        end else begin
            if (cand_s == prev_cand_r) begin
                run_s = streak_r + STW'(1'b1);
            end else begin
                run_s = STW'(1'b1);
            end
            if (int'(run_s) >= HYST) begin
                type_nx_s    = cand_s;
                changed_nx_s = 1'b1;
                streak_nx_s  = {STW{1'b0}};
            end else begin
                streak_nx_s = run_s;
            end
        end
    end

    // Hysteresis state and decided type, updated once per window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_out     <= T_NONE;
            type_valid   <= 1'b0;
            type_changed <= 1'b0;
            streak_r     <= {STW{1'b0}};
            prev_cand_r  <= T_NONE;
        end else if (win_done) begin
            type_out     <= type_nx_s;
            type_valid   <= 1'b1;
            type_changed <= changed_nx_s;
            streak_r     <= streak_nx_s;
            prev_cand_r  <= cand_s;
        end else begin
            type_changed <= 1'b0;
        end
    end

    // One restoring-division step; the first step runs on the win_done cycle
    always_comb begin
        num_s = NW'(diff_s) * NW'(7'd100);
        den_s = {1'b0, env_max} + {1'b0, env_min};
        if (win_done) begin
            q_in_s   = num_s;
            rem_in_s = {ADC_W{1'b0}};
            den_in_s = den_s;
        end else begin
            q_in_s   = div_q_r;
            rem_in_s = div_rem_r;
            den_in_s = div_den_r;
        end
        rem_sh_s = {rem_in_s, q_in_s[NW-1]};
        if (rem_sh_s >= {1'b0, den_in_s}) begin
            rem_out_s = ADC_W'(rem_sh_s - {1'b0, den_in_s});
            q_bit_s   = 1'b1;
        end else begin
            rem_out_s = rem_sh_s[ADC_W-1:0];
            q_bit_s   = 1'b0;
        end
        q_out_s = {q_in_s[NW-2:0], q_bit_s};
        if (q_out_s > NW'(7'd100)) begin
            clip_s = 7'd100;
        end else begin
            clip_s = q_out_s[6:0];
        end
    end

    // Divider sequencing: a new window restarts it, the old result is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy_r  <= 1'b0;
            div_cnt_r   <= {DCW{1'b0}};
            div_q_r     <= {NW{1'b0}};
            div_rem_r   <= {ADC_W{1'b0}};
            div_den_r   <= {ADC_W{1'b0}};
            depth_pct   <= 7'd0;
            depth_valid <= 1'b0;
        end else if (win_done) begin
            if (den_s == {ADC_W{1'b0}}) begin
                div_busy_r  <= 1'b0;
                depth_pct   <= 7'd0;
                depth_valid <= 1'b1;
            end else begin
                div_busy_r  <= 1'b1;
                div_cnt_r   <= DCW'(NW - 1);
                div_q_r     <= q_out_s;
                div_rem_r   <= rem_out_s;
                div_den_r   <= den_s;
                depth_valid <= 1'b0;
            end
        end else if (div_busy_r) begin
            div_q_r   <= q_out_s;
            div_rem_r <= rem_out_s;
            div_cnt_r <= div_cnt_r - DCW'(1'b1);
            if (div_cnt_r == DCW'(1'b1)) begin
                div_busy_r  <= 1'b0;
                depth_pct   <= clip_s;
                depth_valid <= 1'b1;
            end else begin
                depth_valid <= 1'b0;
            end
        end else begin
            depth_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_type_detector.sv
// Scoreboard bench for mod_type_detector with a small window. Each window's
// samples are generated up front, a reference model derives the expected
// envelope, decision and depth from plain arithmetic, and a monitor compares
// them whenever the DUT pulses win_done / depth_valid.
module tb_mod_type_detector;

    localparam int ADC_W  = 10;
    localparam int SUBWIN = 8;
    localparam int NSUB   = 4;
    localparam int LOW_TH = 10;
    localparam int ASK_TH = 20;
    localparam int CW_TH  = 8;
    localparam int HYST   = 2;
    localparam int WIN    = SUBWIN * NSUB;
    localparam int NW     = ADC_W + 7;

    logic             clk;
    logic             rst_n;
    logic             sample_en;
    logic [ADC_W-1:0] ad_data;
    logic [1:0]       type_out;
    logic             type_valid;
    logic             type_changed;
    logic             win_done;
    logic [ADC_W-2:0] env_max;
    logic [ADC_W-2:0] env_min;
    logic [6:0]       depth_pct;
    logic             depth_valid;

    mod_type_detector #(
        .ADC_W(ADC_W), .SUBWIN(SUBWIN), .NSUB(NSUB), .LOW_TH(LOW_TH),
        .ASK_TH(ASK_TH), .CW_TH(CW_TH), .HYST(HYST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .ad_data(ad_data),
        .type_out(type_out), .type_valid(type_valid), .type_changed(type_changed),
        .win_done(win_done), .env_max(env_max), .env_min(env_min),
        .depth_pct(depth_pct), .depth_valid(depth_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int emax;
        int emin;
        int typ;
        int changed;
        int depth;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   win_s[WIN];
    int   m_type  = 0;
    int   m_valid = 0;
    int   hist[$];
    int   pend_type = 0;
    int   pend_div  = 0;
    int   since     = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endtask

    function automatic int rect_of(input int ad);
        int r;
        r = ad - 512;
        if (r < 0) r = -r;
        if (r > 511) r = 511;
        return r;
    endfunction

    function automatic int tone(input int pos, input int a);
        if (pos == 3) return 512 + a;
        if (pos == 7) return 512 - a;
        return 512 + int'($urandom_range(0, 2 * a)) - a;
    endfunction

    // kinds: 0 ASK-like, 1 CW (arg amplitude, 0 = random), 2 AM (arg 1 =
    // envelope 100/300/200/300, else random), 3 all zero, 4 first arg samples
    // at midpoint rest at +300, 5 all midpoint
    task automatic build(input int kind, input int arg);
        int amp[NSUB];
        int a;
        a = (arg != 0) ? arg : int'($urandom_range(20, 500));
        for (int b = 0; b < NSUB; b++) begin
            if (kind == 2 && arg == 1) amp[b] = (b == 0) ? 100 : ((b == 2) ? 200 : 300);
            else amp[b] = int'($urandom_range(50, 400));
        end
        for (int i = 0; i < WIN; i++) begin
            case (kind)
                0: win_s[i] = (i % 4 != 0) ? 503 + int'($urandom_range(0, 18))
                                           : (($urandom_range(0, 1) == 1) ? 762 : 262);
                1: win_s[i] = tone(i % SUBWIN, a);
                2: win_s[i] = tone(i % SUBWIN, amp[i / SUBWIN]);
                3: win_s[i] = 0;
                4: win_s[i] = (i < arg) ? 512 : 812;
                default: win_s[i] = 512;
            endcase
        end
    endtask

    task automatic model_push();
        exp_t e;
        int low, pk, cand, den, all_same;
        e.emax = 0;
        e.emin = 1 << 30;
        low = 0;
        for (int b = 0; b < NSUB; b++) begin
            pk = 0;
            for (int j = 0; j < SUBWIN; j++) begin
                if (rect_of(win_s[b * SUBWIN + j]) > pk) pk = rect_of(win_s[b * SUBWIN + j]);
                if (rect_of(win_s[b * SUBWIN + j]) < LOW_TH) low++;
            end
            if (pk > e.emax) e.emax = pk;
            if (pk < e.emin) e.emin = pk;
        end
        if (low > ASK_TH) cand = 2;
        else if (e.emax - e.emin <= CW_TH) cand = 3;
        else cand = 1;
        den = e.emax + e.emin;
        e.depth = (den == 0) ? 0 : ((e.emax - e.emin) * 100) / den;
        if (e.depth > 100) e.depth = 100;
        e.lat = (den == 0) ? 1 : NW;
        hist.push_back(cand);
        if (hist.size() > HYST) void'(hist.pop_front());
        e.changed = 0;
        if (m_valid == 0) begin
            m_valid   = 1;
            m_type    = cand;
            e.changed = 1;
        end else if (cand != m_type && hist.size() >= HYST) begin
            // switch once the last HYST decisions all agree on a new type
            all_same = 1;
            foreach (hist[k]) if (hist[k] != cand) all_same = 0;
            if (all_same == 1) begin
                m_type    = cand;
                e.changed = 1;
            end
        end
        e.typ = m_type;
        exp_q.push_back(e);
    endtask

    task automatic send(input int gaps);
        for (int i = 0; i < WIN; i++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) begin
                sample_en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            ad_data   = ADC_W'(win_s[i]);
            sample_en = 1'b1;
            @(negedge clk);
        end
        sample_en = 1'b0;
    endtask

    task automatic run_window(input int kind, input int arg, input int gaps);
        build(kind, arg);
        model_push();
        send(gaps);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_type_out"}, int'(type_out), 0);
        check({tag, "_type_valid"}, int'(type_valid), 0);
        check({tag, "_type_changed"}, int'(type_changed), 0);
        check({tag, "_win_done"}, int'(win_done), 0);
        check({tag, "_env_max"}, int'(env_max), 0);
        check({tag, "_env_min"}, int'(env_min), 0);
        check({tag, "_depth_pct"}, int'(depth_pct), 0);
        check({tag, "_depth_valid"}, int'(depth_valid), 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_type = 0;
            pend_div  = 0;
        end else begin
            if (pend_div != 0) since++;
            if (win_done) begin
                if (exp_q.size() == 0) begin
                    flag("win_done_unexpected");
                end else begin
                    cur_e = exp_q.pop_front();
                    check("env_max", int'(env_max), cur_e.emax);
                    check("env_min", int'(env_min), cur_e.emin);
                    pend_type = 1;
                    pend_div  = 1;
                    since     = 0;
                end
            end else if (pend_type != 0) begin
                check("type_out", int'(type_out), cur_e.typ);
                check("type_valid", int'(type_valid), 1);
                check("type_changed", int'(type_changed), cur_e.changed);
                pend_type = 0;
            end else if (type_changed) begin
                flag("type_changed_stray");
            end
            if (depth_valid) begin
                if (pend_div != 0) begin
                    check("depth_pct", int'(depth_pct), cur_e.depth);
                    check("depth_latency", since, cur_e.lat);
                    pend_div = 0;
                end else begin
                    flag("depth_valid_stray");
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, kind, arg;
        rst_n     = 1'b0;
        sample_en = 1'b0;
        ad_data   = {ADC_W{1'b0}};
        repeat (3) @(negedge clk);
        check_zero("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        // first window: midpoint only -> ASK, zero denominator
        run_window(5, 0, 0);
        // hysteresis: AM x3, one ASK, AM, then ASK x2
        run_window(2, 1, 0);
        run_window(2, 1, 0);
        run_window(2, 1, 0);
        run_window(0, 0, 0);
        run_window(2, 1, 0);
        run_window(0, 0, 0);
        run_window(0, 0, 0);
        // CW, low-count boundary, full-scale saturation
        run_window(1, 200, 0);
        run_window(4, 20, 0);
        run_window(4, 21, 0);
        run_window(3, 0, 0);

        // randomized windows, with sample_en gaps on some
        for (int w = 0; w < 16; w++) begin
            kind = int'($urandom_range(0, 5));
            arg  = (kind == 4) ? int'($urandom_range(18, 22)) : 0;
            run_window(kind, arg, int'($urandom_range(0, 1)));
        end
        repeat (40) @(negedge clk);

        // reset in the middle of a division
        run_window(2, 1, 0);
        k = 0;
        while (k < 20 && !win_done) begin
            @(negedge clk);
            k++;
        end
        check("win_done_before_reset", int'(win_done), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_q.delete();
        hist.delete();
        m_type  = 0;
        m_valid = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (NW + 5) @(negedge clk);
        check("after_reset_depth_valid", int'(depth_valid), 0);
        check("after_reset_type_valid", int'(type_valid), 0);

        // fresh decisions after reset, with gaps
        run_window(0, 0, 1);
        run_window(2, 1, 1);
        run_window(2, 1, 1);

        repeat (40) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("division_drained", pend_div, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_type_detector.md
Name: mod_type_detector

Overview:
- Parametrised successor to the front-end signal-type decision in the AM/ASK demodulation path.
- Classifies the ADC stream per measurement window as AM, ASK or unmodulated carrier (CW), with a hysteresis filter on the decision.
- Measures the envelope maximum and minimum over each window and computes the AM modulation depth in percent with a sequential divider.
- Drives the enables of the downstream ask_demod / am_demod blocks and reports ma.

Parameters:
- ADC_W, 10: ADC sample width, unsigned offset-binary; midpoint is 2^(ADC_W-1).
- SUBWIN, 64: samples per sub-block. Must cover at least one carrier period.
- NSUB, 156: sub-blocks per window (window = SUBWIN*NSUB samples). Minimum 2.
- LOW_TH, 10: rectified magnitude below this counts as a "low" sample.
- ASK_TH, 2000: low-sample count per window above which the window is ASK.
- CW_TH, 8: env_max-env_min at or below this (and not ASK) means CW.
- HYST, 2: consecutive identical window decisions required to change type_out. Minimum 1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- sample_en, in, 1: ad_data is valid this cycle.
- ad_data, in, ADC_W: ADC sample.
- type_out, out, 2: decided type, 00 none, 01 AM, 10 ASK, 11 CW.
- type_valid, out, 1: high once the first window has been decided.
- type_changed, out, 1: one-cycle pulse when type_out updates.
- win_done, out, 1: one-cycle pulse at the end of each window.
- env_max, out, ADC_W-1: largest sub-block peak of the last window.
- env_min, out, ADC_W-1: smallest sub-block peak of the last window.
- depth_pct, out, 7: (env_max-env_min)*100/(env_max+env_min), truncated, range 0..100.
- depth_valid, out, 1: one-cycle pulse when depth_pct updates.

Behaviour:
- Reset: all outputs 0, all counters and accumulators 0, divider idle. Reset is honoured mid-window and mid-division; no partial result is emitted.

Per accepted sample (sample_en=1), stage 1, registered:
- centered = ad_data - 2^(ADC_W-1), signed ADC_W+1 bits.
- rect = |centered|, saturated to 2^(ADC_W-1)-1.
- All window statistics use stage-1 outputs, so total latency from a sample to its effect is 1 accepted sample.
- Cycles with sample_en=0 freeze all counters.

Per stage-1 sample:
- If rect<LOW_TH, increment low_cnt (width clog2(SUBWIN*NSUB+1)).
- sub_peak = max(sub_peak, rect).
- On the last sample of a sub-block:
  - win_max = max(win_max, final sub_peak) and win_min = min(win_min, final sub_peak). The final sub_peak includes the current sample.
  - sub_peak restarts at 0.
  - win_min is initialised to all-ones at window start.

Window end (last sample of sub-block NSUB), next cycle:
- win_done=1; env_max/env_min load win_max/win_min.
- The decision cand is evaluated in order:
  - low_cnt>ASK_TH gives ASK (strictly greater; a count equal to ASK_TH is not ASK).
  - Otherwise env_max-env_min<=CW_TH gives CW.
  - Otherwise AM.
- low_cnt, win_max and win_min reset for the next window. A sample arriving in the same cycle counts toward the new window.

Hysteresis:
- First decided window after reset: type_out=cand, type_valid=1, type_changed=1.
- Afterwards a streak counter tracks cand!=type_out. It increments when cand equals the previous cand; otherwise it reloads to 1.
- When streak reaches HYST, type_out=cand, type_changed=1 and streak clears.
- cand==type_out clears streak.
- With HYST=1 every differing window switches immediately.

Depth divider:
- Started at win_done with num=(env_max-env_min)*100 and den=env_max+env_min.
- Restoring, one quotient bit per cycle, ADC_W+7 cycles.
- On completion: depth_pct=quotient clipped to 100, depth_valid=1.
- den==0 gives depth_pct=0 with depth_valid after 1 cycle.
- A new win_done while the divider is busy aborts the division and restarts it with the new operands; the old result is never emitted.
- The depth is computed for every type; consumers qualify it with type_out.

Test Plan:
- Constant ad_data=512 (rect 0), ADC_W=10, small window (SUBWIN=8, NSUB=4, ASK_TH=20) → low_cnt=32>20 → type_out=10, type_valid and type_changed pulse 1 cycle after the first win_done.
- Sine amplitude 200 around 512, SUBWIN ≥ period → env_max≈env_min≈200, CW (11); depth_pct=0 at ADC_W+7 cycles after win_done.
- AM with envelope 100..300 → AM (01), depth_pct=50 (200*100/400), env_max=300, env_min=100.
- HYST=2: AM for 3 windows, then 1 ASK window, then AM → type_out stays AM, no type_changed; 2 consecutive ASK windows → switch on the 2nd win_done.
- sample_en toggling 1/0 → results identical to a contiguous stream, with win_done delayed accordingly; rst_n asserted mid-division → outputs 0 immediately, no depth_valid.
- Boundary: low_cnt exactly ASK_TH → not ASK; all samples at full scale 0 → rect saturates to 511, no overflow; den=0 path → depth_pct=0.
